// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JUMP/BRANCH/CALL/RET with an optional return-address stack (enable with PC_RAS_EN).
// Latency: one cycle; op sampled on a rising edge is reflected in pc and flags right after that edge.
// Backpressure: stall=1 freezes pc, stack and flags and discards op; pulse flags read 0 the next cycle.
module pc_sequencer #(
    parameter int                    PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                    INC_STEP     = 1,
    parameter int                    STACK_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                stall,
    input  logic [2:0]          op,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [PC_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_check
        $error("pc_sequencer: STACK_DEPTH must be a power of two >= 2");
    end

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                taken_q, taken_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                advance;

    assign pc_inc  = pc_q + PC_WIDTH'(INC_STEP);
    assign advance = en && !stall;

`ifdef PC_RAS_EN
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] ras_q [STACK_DEPTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                push_vld;
    logic [PTR_W-1:0]    push_idx;
    logic [PTR_W-1:0]    top_idx;

    assign push_idx = cnt_q[PTR_W-1:0];
    assign top_idx  = PTR_W'(cnt_q - 1'b1);

    always_comb begin
        pc_d     = pc_q;
        taken_d  = 1'b0;
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        push_vld = 1'b0;
        if (advance) begin
            case (op)
                OP_INC:    pc_d = pc_inc;
                OP_JUMP:   begin pc_d = target;        taken_d = 1'b1; end
                OP_BRANCH: begin pc_d = pc_q + offset; taken_d = 1'b1; end
                OP_CALL: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    // A call on a full stack still redirects; only the push is lost.
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_vld = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty_q) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = ras_q[top_idx];
                        taken_d = 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(STACK_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_vld && !reset) begin
            ras_q[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stack_empty = empty_q;
    assign stack_full  = full_q;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;
`else
    // Without a stack, CALL degenerates to JUMP and RET to INC.
    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        if (advance) begin
            case (op)
                OP_INC, OP_RET:     pc_d = pc_inc;
                OP_JUMP, OP_CALL:   begin pc_d = target;        taken_d = 1'b1; end
                OP_BRANCH:          begin pc_d = pc_q + offset; taken_d = 1'b1; end
                default: ;
            endcase
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_ovf   = 1'b0;
    assign stack_unf   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign pc    = pc_q;
    assign taken = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected state, a monitor pops and compares each cycle.
module tb_pc_sequencer;

    localparam logic [2:0] INC = 3'b000, JMP = 3'b001, BR = 3'b010, CALL = 3'b011,
                           RET = 3'b100, HOLD = 3'b101, RSV = 3'b110;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic       tk;
        logic       em;
        logic       fu;
        logic       ov;
        logic       un;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] op = INC;
    logic [7:0] target = '0;
    logic [7:0] offset = '0;
    logic [7:0] pc;
    logic       taken, stack_empty, stack_full, stack_ovf, stack_unf;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer #(
        .PC_WIDTH(8), .RESET_VECTOR(8'h10), .INC_STEP(1), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .op(op),
        .target(target), .offset(offset), .pc(pc), .taken(taken),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic e, input logic s,
                        input logic [2:0] o, input logic [7:0] t, input logic [7:0] f,
                        input logic [7:0] xpc, input logic xtk, input logic xem,
                        input logic xfu, input logic xov, input logic xun);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; stall = s; op = o; target = t; offset = f;
        x.tag = tag; x.pc = xpc; x.tk = xtk; x.em = xem; x.fu = xfu; x.ov = xov; x.un = xun;
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle the DUT presents a fresh pc/flag set.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                n_cmp++;
                if ({pc, taken, stack_empty, stack_full, stack_ovf, stack_unf} !==
                    {x.pc, x.tk, x.em, x.fu, x.ov, x.un}) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h tk=%b em=%b fu=%b ov=%b un=%b, want pc=%h tk=%b em=%b fu=%b ov=%b un=%b",
                             x.tag, pc, taken, stack_empty, stack_full, stack_ovf, stack_unf,
                             x.pc, x.tk, x.em, x.fu, x.ov, x.un);
                end
            end
        end
    end

    initial begin
        //          tag        r  e  s  op    tgt    off    pc                      tk      em    fu        ov      un
        step("reset",      1, 1, 0, INC,  8'h00, 8'h00, 8'h10,                  0,      1,    0,        0,      0);
        step("inc1",       0, 1, 0, INC,  8'h00, 8'h00, 8'h11,                  0,      1,    0,        0,      0);
        step("inc2",       0, 1, 0, INC,  8'h00, 8'h00, 8'h12,                  0,      1,    0,        0,      0);
        step("inc3",       0, 1, 0, INC,  8'h00, 8'h00, 8'h13,                  0,      1,    0,        0,      0);
        step("jump20",     0, 1, 0, JMP,  8'h20, 8'h00, 8'h20,                  1,      1,    0,        0,      0);
        step("branch_neg", 0, 1, 0, BR,   8'h00, 8'hF8, 8'h18,                  1,      1,    0,        0,      0);
        step("jumpFE",     0, 1, 0, JMP,  8'hFE, 8'h00, 8'hFE,                  1,      1,    0,        0,      0);
        step("incFF",      0, 1, 0, INC,  8'h00, 8'h00, 8'hFF,                  0,      1,    0,        0,      0);
        step("inc_wrap",   0, 1, 0, INC,  8'h00, 8'h00, 8'h00,                  0,      1,    0,        0,      0);
        step("jump05",     0, 1, 0, JMP,  8'h05, 8'h00, 8'h05,                  1,      1,    0,        0,      0);
        step("call40",     0, 1, 0, CALL, 8'h40, 8'h00, 8'h40,                  1,      !RAS, 0,        0,      0);
        step("inc41",      0, 1, 0, INC,  8'h00, 8'h00, 8'h41,                  0,      !RAS, 0,        0,      0);
        step("ret06",      0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h06 : 8'h42,    RAS,    1,    0,        0,      0);
        step("call40b",    0, 1, 0, CALL, 8'h40, 8'h00, 8'h40,                  1,      !RAS, 0,        0,      0);
        step("ret_b2b",    0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h07 : 8'h41,    RAS,    1,    0,        0,      0);
        step("jump00",     0, 1, 0, JMP,  8'h00, 8'h00, 8'h00,                  1,      1,    0,        0,      0);
        step("callA",      0, 1, 0, CALL, 8'h50, 8'h00, 8'h50,                  1,      !RAS, 0,        0,      0);
        step("callB",      0, 1, 0, CALL, 8'h60, 8'h00, 8'h60,                  1,      !RAS, 0,        0,      0);
        step("callC",      0, 1, 0, CALL, 8'h70, 8'h00, 8'h70,                  1,      !RAS, 0,        0,      0);
        step("callD_full", 0, 1, 0, CALL, 8'h80, 8'h00, 8'h80,                  1,      !RAS, RAS,      0,      0);
        step("callE_ovf",  0, 1, 0, CALL, 8'h90, 8'h00, 8'h90,                  1,      !RAS, RAS,      RAS,    0);
        step("ret71",      0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h71 : 8'h91,    RAS,    !RAS, 0,        0,      0);
        step("ret61",      0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h61 : 8'h92,    RAS,    !RAS, 0,        0,      0);
        step("ret51",      0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h51 : 8'h93,    RAS,    !RAS, 0,        0,      0);
        step("ret01",      0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h01 : 8'h94,    RAS,    1,    0,        0,      0);
        step("ret_unf",    0, 1, 0, RET,  8'h00, 8'h00, RAS ? 8'h02 : 8'h95,    0,      1,    0,        0,      RAS);
        step("unf_clear",  0, 1, 0, INC,  8'h00, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("stall1",     0, 1, 1, JMP,  8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("stall2",     0, 1, 1, JMP,  8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("stall3",     0, 1, 1, JMP,  8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("en_low",     0, 0, 0, JMP,  8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("hold",       0, 1, 0, HOLD, 8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("reserved",   0, 1, 0, RSV,  8'hAA, 8'h00, RAS ? 8'h03 : 8'h96,    0,      1,    0,        0,      0);
        step("call30",     0, 1, 0, CALL, 8'h30, 8'h00, 8'h30,                  1,      !RAS, 0,        0,      0);
        step("rst_stall",  1, 1, 1, JMP,  8'hAA, 8'h00, 8'h10,                  0,      1,    0,        0,      0);
        step("rst_op",     1, 1, 0, JMP,  8'hAA, 8'h00, 8'h10,                  0,      1,    0,        0,      0);
        step("inc_post",   0, 1, 0, INC,  8'h00, 8'h00, 8'h11,                  0,      1,    0,        0,      0);
        step("branch_pos", 0, 1, 0, BR,   8'h00, 8'h05, 8'h16,                  1,      1,    0,        0,      0);
        step("taken_clr",  0, 1, 0, HOLD, 8'h00, 8'h00, 8'h16,                  0,      1,    0,        0,      0);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
